// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot controller.
package imem_boot_pkg;

   // Controller sequencing states
   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StWrite,
      StFlush,
      StRun
   } state_e;

   // Loader bytes that make up one instruction word
   localparam int unsigned BYTES_PER_WORD = 3;
   localparam int unsigned BYTE_W         = 8;

   // Bit positions of each little-endian byte lane inside the word
   localparam int unsigned LANE0_LSB = 0;
   localparam int unsigned LANE1_LSB = 8;
   localparam int unsigned LANE2_LSB = 16;

endpackage

// File: rtl/imem_boot_controller_if.sv
// Byte-stream handshake from the program loader and the instruction-memory write/address port.
interface imem_boot_controller_if #(
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned INSTR_W = 17
);

   logic               byte_valid;
   logic [7:0]         byte_data;
   logic               byte_ready;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_we;
   logic [INSTR_W-1:0] imem_wdata;

   // Controller side: sinks loader bytes, drives the memory port
   modport master (
      input  byte_valid,
      input  byte_data,
      output byte_ready,
      output imem_addr,
      output imem_we,
      output imem_wdata
   );

   // Environment side: loader source and memory sink
   modport slave (
      output byte_valid,
      output byte_data,
      input  byte_ready,
      input  imem_addr,
      input  imem_we,
      input  imem_wdata
   );

endinterface

// File: rtl/word_assembler.sv
// Collects three little-endian loader bytes into one instruction word.
// The output word only changes when the third byte lands, so it holds the
// last complete word while the next one is being gathered.
module word_assembler
   import imem_boot_pkg::*;
#(
   parameter int unsigned INSTR_W = 17
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,        // drop any partial word
   input  logic               byte_accept,  // byte handshake completes this cycle
   input  logic [7:0]         byte_data,
   output logic               word_valid,   // third byte accepted this cycle
   output logic [INSTR_W-1:0] word
);

   logic [1:0]         byte_cnt_q, byte_cnt_d;
   logic [7:0]         lane0_q, lane0_d;
   logic [7:0]         lane1_q, lane1_d;
   logic [INSTR_W-1:0] word_q, word_d;
   logic               last_byte;

   assign last_byte  = (byte_cnt_q == 2'(BYTES_PER_WORD - 1));
   assign word_valid = byte_accept && last_byte && !clear;
   assign word       = word_q;

   // Next-state for byte counter, staged lanes and assembled word
   always_comb begin
      byte_cnt_d = byte_cnt_q;
      lane0_d    = lane0_q;
      lane1_d    = lane1_q;
      word_d     = word_q;
      if (clear) begin
         byte_cnt_d = 2'd0;
      end else if (byte_accept) begin
         unique case (byte_cnt_q)
            2'd0: begin
               lane0_d    = byte_data;
               byte_cnt_d = 2'd1;
            end
            2'd1: begin
               lane1_d    = byte_data;
               byte_cnt_d = 2'd2;
            end
            default: begin
               // Only bit 0 of the top byte is meaningful; bits [7:1] are dropped
               word_d                         = '0;
               word_d[LANE0_LSB +: BYTE_W]    = lane0_q;
               word_d[LANE1_LSB +: BYTE_W]    = lane1_q;
               word_d[LANE2_LSB]              = byte_data[0];
               byte_cnt_d                     = 2'd0;
            end
         endcase
      end
   end

   // Byte counter, lane and word registers
   always_ff @(posedge clk) begin
      if (reset) begin
         byte_cnt_q <= 2'd0;
         lane0_q    <= '0;
         lane1_q    <= '0;
         word_q     <= '0;
      end else begin
         byte_cnt_q <= byte_cnt_d;
         lane0_q    <= lane0_d;
         lane1_q    <= lane1_d;
         word_q     <= word_d;
      end
   end

endmodule

// File: rtl/imem_boot_controller.sv
// Fetch-stage sequencer: streams a program into instruction memory while fetch is
// stalled, flushes the fetch pipeline, then hands the memory address to the PC.
module imem_boot_controller
   import imem_boot_pkg::*;
#(
   parameter int unsigned ADDR_W       = 12,
   parameter int unsigned INSTR_W      = 17,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start_load,
   input  logic                   start_run,
   input  logic                   halt,
   input  logic [ADDR_W:0]        prog_len,
   input  logic [ADDR_W-1:0]      pc_f,
   imem_boot_controller_if.master bus,
   output logic                   fetch_stall,
   output logic                   fetch_flush,
   output logic                   running,
   output logic                   load_done,
   output logic                   load_err,
   output logic [ADDR_W:0]        words_loaded
);

   localparam int unsigned CNT_W   = ADDR_W + 1;
   localparam int unsigned FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     len_q, len_d;
   logic [ADDR_W-1:0]    word_cnt_q, word_cnt_d;
   logic [CNT_W-1:0]     words_loaded_q, words_loaded_d;
   logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
   logic                 load_done_q, load_done_d;
   logic                 load_err_q, load_err_d;

   logic                 byte_ready_int;
   logic                 asm_clear;
   logic                 asm_word_valid;
   logic [INSTR_W-1:0]   asm_word;
   logic                 last_word;
   logic                 flush_last;
   logic                 len_nonzero;

   assign byte_ready_int = (state_q == StLoad);
   assign len_nonzero    = (prog_len != '0);
   // word_cnt is widened so a 2^ADDR_W-word program still terminates after wrapping
   assign last_word      = (({1'b0, word_cnt_q} + CNT_W'(1)) == len_q);
   assign flush_last     = (flush_cnt_q == FLUSH_W'(FLUSH_CYCLES - 1));

   word_assembler #(
      .INSTR_W (INSTR_W)
   ) u_word_assembler (
      .clk         (clk),
      .reset       (reset),
      .clear       (asm_clear),
      .byte_accept (bus.byte_valid && byte_ready_int),
      .byte_data   (bus.byte_data),
      .word_valid  (asm_word_valid),
      .word        (asm_word)
   );

   // Next-state, counter updates and pulse requests
   always_comb begin
      state_d        = state_q;
      len_d          = len_q;
      word_cnt_d     = word_cnt_q;
      words_loaded_d = words_loaded_q;
      flush_cnt_d    = '0;
      load_done_d    = 1'b0;
      load_err_d     = 1'b0;
      asm_clear      = 1'b0;
      unique case (state_q)
         StIdle: begin
            // A load request takes priority over a run request
            if (start_load) begin
               if (len_nonzero) begin
                  state_d        = StLoad;
                  len_d          = prog_len;
                  word_cnt_d     = '0;
                  words_loaded_d = '0;
                  asm_clear      = 1'b1;
               end else begin
                  load_err_d = 1'b1;
               end
            end else if (start_run) begin
               state_d = StFlush;
            end
         end
         StLoad: begin
            if (asm_word_valid) begin
               state_d = StWrite;
            end
         end
         StWrite: begin
            word_cnt_d     = word_cnt_q + ADDR_W'(1);
            words_loaded_d = words_loaded_q + CNT_W'(1);
            if (last_word) begin
               load_done_d = 1'b1;
               state_d     = StFlush;
            end else begin
               state_d = StLoad;
            end
         end
         StFlush: begin
            if (flush_last) begin
               state_d = StRun;
            end else begin
               flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
            end
         end
         StRun: begin
            // Halt wins over a simultaneous reload; a zero-length reload keeps running
            if (halt) begin
               state_d = StIdle;
            end else if (start_load) begin
               if (len_nonzero) begin
                  state_d        = StLoad;
                  len_d          = prog_len;
                  word_cnt_d     = '0;
                  words_loaded_d = '0;
                  asm_clear      = 1'b1;
               end else begin
                  load_err_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State, counters and registered pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= StIdle;
         len_q          <= '0;
         word_cnt_q     <= '0;
         words_loaded_q <= '0;
         flush_cnt_q    <= '0;
         load_done_q    <= 1'b0;
         load_err_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         len_q          <= len_d;
         word_cnt_q     <= word_cnt_d;
         words_loaded_q <= words_loaded_d;
         flush_cnt_q    <= flush_cnt_d;
         load_done_q    <= load_done_d;
         load_err_q     <= load_err_d;
      end
   end

   // Output decode; in RUN the memory address follows the fetch PC combinationally
   always_comb begin
      bus.byte_ready = byte_ready_int;
      bus.imem_we    = (state_q == StWrite);
      bus.imem_wdata = asm_word;
      bus.imem_addr  = (state_q == StRun) ? pc_f : word_cnt_q;
      fetch_stall    = (state_q != StRun);
      fetch_flush    = (state_q == StFlush);
      running        = (state_q == StRun);
      load_done      = load_done_q;
      load_err       = load_err_q;
      words_loaded   = words_loaded_q;
   end

endmodule

// File: tb/tb_imem_boot_controller.sv
// Directed bench for imem_boot_controller: per-cycle vector table plus a
// random-byte-valid load sequence checked against a small scoreboard.
module tb_imem_boot_controller;

   localparam int unsigned ADDR_W  = 12;
   localparam int unsigned INSTR_W = 17;

   logic              clk;
   logic              reset;
   logic              start_load;
   logic              start_run;
   logic              halt;
   logic [ADDR_W:0]   prog_len;
   logic [ADDR_W-1:0] pc_f;
   logic              fetch_stall;
   logic              fetch_flush;
   logic              running;
   logic              load_done;
   logic              load_err;
   logic [ADDR_W:0]   words_loaded;

   imem_boot_controller_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

   imem_boot_controller #(
      .ADDR_W       (ADDR_W),
      .INSTR_W      (INSTR_W),
      .FLUSH_CYCLES (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start_load   (start_load),
      .start_run    (start_run),
      .halt         (halt),
      .prog_len     (prog_len),
      .pc_f         (pc_f),
      .bus          (bus),
      .fetch_stall  (fetch_stall),
      .fetch_flush  (fetch_flush),
      .running      (running),
      .load_done    (load_done),
      .load_err     (load_err),
      .words_loaded (words_loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {ready, we, addr[11:0], wdata[16:0], stall, flush, run, done, err, words[12:0]}
   typedef logic [48:0] obs_t;

   typedef struct {
      logic        rst;
      logic        sl;
      logic        sr;
      logic        h;
      logic [12:0] len;
      logic        bv;
      logic [7:0]  bd;
      logic [11:0] pc;
      logic        ca;   // compare imem_addr on this row
      obs_t        exp;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_err    = 0;

   function automatic obs_t pack(input logic rdy, input logic we, input logic [11:0] addr,
                                 input logic [16:0] wd, input logic st, input logic fl,
                                 input logic rn, input logic dn, input logic er,
                                 input logic [12:0] wl);
      return {rdy, we, addr, wd, st, fl, rn, dn, er, wl};
   endfunction

   function automatic vec_t v(input logic rst, input logic sl, input logic sr, input logic h,
                              input int len, input logic bv, input int bd, input int pc,
                              input logic ca, input logic rdy, input logic we, input int addr,
                              input int wd, input logic st, input logic fl, input logic rn,
                              input logic dn, input logic er, input int wl);
      vec_t r;
      r.rst = rst; r.sl = sl; r.sr = sr; r.h = h;
      r.len = 13'(len); r.bv = bv; r.bd = 8'(bd); r.pc = 12'(pc); r.ca = ca;
      r.exp = pack(rdy, we, 12'(addr), 17'(wd), st, fl, rn, dn, er, 13'(wl));
      return r;
   endfunction

   function automatic obs_t observe();
      return pack(bus.byte_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, fetch_stall,
                  fetch_flush, running, load_done, load_err, words_loaded);
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard data for the random-valid load: three words, nine bytes
   logic [7:0]  stream [9];
   logic [16:0] words3 [3];

   initial begin
      obs_t mask;
      int   bi;
      int   nw;
      logic seen_done;

      reset = 1'b1; start_load = 1'b0; start_run = 1'b0; halt = 1'b0;
      prog_len = '0; pc_f = '0; bus.byte_valid = 1'b0; bus.byte_data = '0;

      //             rst sl sr h len bv bd    pc     ca rdy we addr wd      st fl rn dn er wl
      // reset state
      vecs.push_back(v(1, 0, 0, 0, 0, 0, 'h00, 'h000, 1, 0, 0, 0, 'h00000, 1, 0, 0, 0, 0, 0));
      // two-word load, back-to-back bytes
      vecs.push_back(v(0, 1, 0, 0, 2, 0, 'h00, 'h000, 1, 1, 0, 0, 'h00000, 1, 0, 0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 1, 'h34, 'h000, 1, 1, 0, 0, 'h00000, 1, 0, 0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 1, 'h12, 'h000, 1, 1, 0, 0, 'h00000, 1, 0, 0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 1, 'h01, 'h000, 1, 0, 1, 0, 'h11234, 1, 0, 0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 'h00, 'h000, 1, 1, 0, 1, 'h11234, 1, 0, 0, 0, 0, 1));
      vecs.push_back(v(0, 0, 0, 0, 0, 1, 'hCD, 'h000, 1, 1, 0, 1, 'h11234, 1, 0, 0, 0, 0, 1));
      vecs.push_back(v(0, 0, 0, 0, 0, 1, 'hAB, 'h000, 1, 1, 0, 1, 'h11234, 1, 0, 0, 0, 0, 1));
      vecs.push_back(v(0, 0, 0, 0, 0, 1, 'h00, 'h000, 1, 0, 1, 1, 'h0ABCD, 1, 0, 0, 0, 0, 1));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 'h00, 'h000, 0, 0, 0, 0, 'h0ABCD, 1, 1, 0, 1, 0, 2));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 'h00, 'h000, 0, 0, 0, 0, 'h0ABCD, 1, 1, 0, 0, 0, 2));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 'h00, 'h005, 1, 0, 0, 5, 'h0ABCD, 0, 0, 1, 0, 0, 2));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 'h00, 'h123, 1, 0, 0, 'h123, 'h0ABCD, 0, 0, 1, 0, 0, 2));
      // halt and start_load together in RUN: halt wins
      vecs.push_back(v(0, 1, 0, 1, 3, 0, 'h00, 'h007, 0, 0, 0, 0, 'h0ABCD, 1, 0, 0, 0, 0, 2));
      // zero-length load in IDLE
      vecs.push_back(v(0, 1, 0, 0, 0, 0, 'h00, 'h000, 0, 0, 0, 0, 'h0ABCD, 1, 0, 0, 0, 1, 2));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 'h00, 'h000, 0, 0, 0, 0, 'h0ABCD, 1, 0, 0, 0, 0, 2));
      // start_load with start_run: load wins; byte2[7:1] ignored
      vecs.push_back(v(0, 1, 1, 0, 1, 0, 'h00, 'h000, 1, 1, 0, 0, 'h0ABCD, 1, 0, 0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 1, 'hFF, 'h000, 1, 1, 0, 0, 'h0ABCD, 1, 0, 0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 1, 'hFF, 'h000, 1, 1, 0, 0, 'h0ABCD, 1, 0, 0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 1, 'hFF, 'h000, 1, 0, 1, 0, 'h1FFFF, 1, 0, 0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 'h00, 'h000, 0, 0, 0, 0, 'h1FFFF, 1, 1, 0, 1, 0, 1));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 'h00, 'h000, 0, 0, 0, 0, 'h1FFFF, 1, 1, 0, 0, 0, 1));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 'h00, 'h000, 1, 0, 0, 0, 'h1FFFF, 0, 0, 1, 0, 0, 1));
      // zero-length load in RUN: error pulse, keeps running
      vecs.push_back(v(0, 1, 0, 0, 0, 0, 'h00, 'h009, 1, 0, 0, 9, 'h1FFFF, 0, 0, 1, 0, 1, 1));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 'h00, 'h009, 1, 0, 0, 9, 'h1FFFF, 0, 0, 1, 0, 0, 1));
      vecs.push_back(v(0, 0, 0, 1, 0, 0, 'h00, 'h009, 0, 0, 0, 0, 'h1FFFF, 1, 0, 0, 0, 0, 1));
      // reset in the middle of word 1 of a four-word load
      vecs.push_back(v(0, 1, 0, 0, 4, 0, 'h00, 'h000, 1, 1, 0, 0, 'h1FFFF, 1, 0, 0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 1, 'h55, 'h000, 1, 1, 0, 0, 'h1FFFF, 1, 0, 0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 1, 'h66, 'h000, 1, 1, 0, 0, 'h1FFFF, 1, 0, 0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 1, 'h07, 'h000, 1, 0, 1, 0, 'h16655, 1, 0, 0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 'h00, 'h000, 1, 1, 0, 1, 'h16655, 1, 0, 0, 0, 0, 1));
      vecs.push_back(v(0, 1, 0, 0, 3, 1, 'h88, 'h000, 1, 1, 0, 1, 'h16655, 1, 0, 0, 0, 0, 1));
      vecs.push_back(v(0, 0, 0, 0, 0, 1, 'h99, 'h000, 1, 1, 0, 1, 'h16655, 1, 0, 0, 0, 0, 1));
      vecs.push_back(v(1, 0, 0, 0, 0, 0, 'h00, 'h000, 1, 0, 0, 0, 'h00000, 1, 0, 0, 0, 0, 0));
      vecs.push_back(v(0, 1, 0, 0, 1, 0, 'h00, 'h000, 1, 1, 0, 0, 'h00000, 1, 0, 0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 1, 'h11, 'h000, 1, 1, 0, 0, 'h00000, 1, 0, 0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 1, 'h22, 'h000, 1, 1, 0, 0, 'h00000, 1, 0, 0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 1, 'h00, 'h000, 1, 0, 1, 0, 'h02211, 1, 0, 0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 'h00, 'h000, 0, 0, 0, 0, 'h02211, 1, 1, 0, 1, 0, 1));

      foreach (vecs[i]) begin
         reset          = vecs[i].rst;
         start_load     = vecs[i].sl;
         start_run      = vecs[i].sr;
         halt           = vecs[i].h;
         prog_len       = vecs[i].len;
         bus.byte_valid = vecs[i].bv;
         bus.byte_data  = vecs[i].bd;
         pc_f           = vecs[i].pc;
         step();
         mask = vecs[i].ca ? '1 : ~pack(0, 0, 12'hFFF, 0, 0, 0, 0, 0, 0, 0);
         check($sformatf("vec%0d", i), 64'(observe() & mask), 64'(vecs[i].exp & mask));
      end

      // Three-word load with byte_valid toggling at random
      stream = '{8'hEF, 8'hBE, 8'h03, 8'h01, 8'h02, 8'hFE, 8'hA5, 8'h5A, 8'h81};
      words3 = '{17'h1BEEF, 17'h00201, 17'h15AA5};
      reset = 1'b1; start_load = 1'b0; bus.byte_valid = 1'b0;
      step();
      reset = 1'b0; start_load = 1'b1; prog_len = 13'd3;
      step();
      start_load = 1'b0;
      bi = 0; nw = 0; seen_done = 1'b0;
      for (int c = 0; c < 200 && !seen_done; c++) begin
         bus.byte_valid = (bi < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.byte_data  = (bi < 9) ? stream[bi] : 8'h00;
         if (bus.byte_valid && bus.byte_ready) bi++;
         step();
         if (bus.imem_we) begin
            if (nw < 3) begin
               check($sformatf("rnd_addr%0d", nw), 64'(bus.imem_addr), 64'(nw));
               check($sformatf("rnd_data%0d", nw), 64'(bus.imem_wdata), 64'(words3[nw]));
            end
            check($sformatf("rnd_ready_in_write%0d", nw), 64'(bus.byte_ready), 64'd0);
            check($sformatf("rnd_bytes_before_write%0d", nw), 64'(bi), 64'(3 * (nw + 1)));
            nw++;
         end
         if (load_done) seen_done = 1'b1;
      end
      bus.byte_valid = 1'b0;
      check("rnd_load_done_seen", 64'(seen_done), 64'd1);
      check("rnd_write_count", 64'(nw), 64'd3);
      check("rnd_words_loaded", 64'(words_loaded), 64'd3);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/imem_boot_controller.md
Name: imem_boot_controller

Overview:
Sequences the fetch stage and owns the instruction-memory write/address port. Loads a program from a byte stream (valid/ready) into instruction memory while holding fetch stalled, then flushes and releases fetch. In RUN, the memory address follows the fetch PC. Sits between the program loader (UART/host side) and the Fetch stage's instruction memory and PC register.

Parameters:
ADDR_W, 12, instruction-memory address width (PC width)
INSTR_W, 17, instruction word width
FLUSH_CYCLES, 2, cycles fetch_flush is held before RUN (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start_load  in  1  request to load a program (sampled in IDLE/RUN)
start_run  in  1  request to run the resident program (sampled in IDLE)
halt  in  1  stop execution, return to IDLE (sampled in RUN)
prog_len  in  ADDR_W+1  number of words to load, 0..4096, latched on start_load
byte_valid  in  1  loader byte valid
byte_data  in  8  loader byte
byte_ready  out  1  controller accepts byte this cycle
pc_f  in  ADDR_W  current fetch PC
imem_addr  out  ADDR_W  instruction-memory address
imem_we  out  1  instruction-memory write enable
imem_wdata  out  INSTR_W  instruction-memory write data
fetch_stall  out  1  hold PC and fetch pipeline register
fetch_flush  out  1  clear PC to 0 and zero the fetch pipeline register
running  out  1  high in RUN
load_done  out  1  one-cycle pulse when the last word is written
load_err  out  1  one-cycle pulse on start_load with prog_len==0
words_loaded  out  ADDR_W+1  count of words written in the current/last load

Behaviour:
- States: IDLE, LOAD, WRITE, FLUSH, RUN. Registered state; outputs decoded from state and counters.
- Reset: state=IDLE. byte_ready=0, imem_we=0, imem_wdata=0, imem_addr=0, fetch_stall=1, fetch_flush=0, running=0, load_done=0, load_err=0, words_loaded=0. Byte/word/flush counters are cleared; any partial word is discarded. Memory words already written are untouched.
- IDLE: fetch_stall=1.
  - start_load with prog_len!=0 -> LOAD. Latch len, clear word_cnt, byte_cnt and words_loaded.
  - start_load with prog_len==0 -> pulse load_err next cycle and stay in IDLE.
  - start_run (without start_load) -> FLUSH.
  - start_load and start_run together: load wins.
- LOAD: byte_ready=1, fetch_stall=1, imem_addr=word_cnt.
  - Each byte_valid&&byte_ready is accepted, little-endian: byte0 -> wdata[7:0], byte1 -> wdata[15:8], byte2 bit0 -> wdata[16]. byte2[7:1] is ignored.
  - The third accepted byte moves the state to WRITE.
  - start_load is ignored in LOAD.
- WRITE (exactly 1 cycle): imem_we=1, imem_addr=word_cnt, imem_wdata=assembled word, byte_ready=0.
  - Next cycle: word_cnt++ and words_loaded++.
  - If word_cnt+1==len: pulse load_done and go to FLUSH. Otherwise return to LOAD with byte_cnt=0.
  - word_cnt wraps at 2^ADDR_W; len==4096 writes every address exactly once.
- FLUSH: fetch_stall=1, fetch_flush=1 for exactly FLUSH_CYCLES cycles (counter), then RUN.
- RUN: running=1, fetch_stall=0, imem_addr=pc_f (combinational pass-through), imem_we=0.
  - halt -> IDLE.
  - start_load -> LOAD, with the same latch rules as IDLE, including load_err when len==0 (stays in RUN in that case).
  - halt and start_load together: halt wins.
- Latency: first instruction fetched from address 0 on the first RUN cycle. From start_load to load_done = 4*N cycles plus byte-stall cycles for N words.
- imem_wdata holds its last assembled value outside WRITE. imem_we is never high outside WRITE.

Decomposition:
- Package imem_boot_pkg holds:
  - state enum typedef (IDLE, LOAD, WRITE, FLUSH, RUN)
  - BYTES_PER_WORD=3 constant
  - byte-lane bit positions
- One natural sub-module: word_assembler, which handles byte_cnt and shift/assemble logic and outputs word_valid and word. The FSM, counters and address mux stay in the top module.

Test Plan:
- Reset, then start_load with prog_len=2 and bytes 0x34,0x12,0x01,0xCD,0xAB,0x00 streamed back-to-back. Expect imem_we pulses with (addr 0, data 0x11234) and (addr 1, data 0x0ABCD). load_done is high one cycle after the second write. fetch_flush is high 2 cycles, then running=1 and imem_addr tracks pc_f.
- byte_valid toggled randomly during a 3-word load. Expect exactly 3 writes with correct data, no write while byte_valid is low, byte_ready=0 in each WRITE cycle, and words_loaded=3.
- start_load with prog_len=0 in IDLE. Expect a load_err single pulse, state stays IDLE, fetch_stall=1, and no imem_we.
- start_load and start_run in the same IDLE cycle. Expect entry to LOAD (byte_ready=1) and no flush.
- reset asserted after 2 bytes of word 1 in a prog_len=4 load. Expect all outputs at reset values the next cycle. A fresh load restarts at addr 0 with the partial bytes discarded.
- In RUN, assert halt and start_load together. Expect IDLE, running=0, and fetch_stall=1 the next cycle.
